multicycle_control_unit: RTL and testbench

- Sequential successor to the single-cycle RV32I opcode decoder.
- FSM-driven control unit for a multi-cycle RV32I core. Sequences FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction and data memory, and adds LUI/AUIPC/SYSTEM decode.
- Adds halt on illegal opcode or ECALL/EBREAK, plus a memory-wait timeout.
- Sits between the IR opcode field and the datapath muxes/enables.

---
 rtl/multicycle_control_unit.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FSM control unit for a multi-cycle RV32I core
// Optional retire counter: define MCU_RETIRE_CNT_EN.
module multicycle_control_unit #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic [6:0]       i_opcode,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  output logic             o_dmem_req,
  input  logic             i_dmem_ack,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_branch,
  output logic             o_jump,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_mem_to_reg,
  output logic             o_alu_src,
  output logic             o_reg_write,
  output logic [1:0]       o_aluop,
  output logic             o_halt,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [CNT_W-1:0] o_retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_L, C_S, C_B, C_JAL, C_JALR, C_LUI, C_AUIPC, C_SYS, C_ILL
  } cls_t;

  state_t          r_state;
  cls_t            r_cls;
  cls_t            w_cls;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_halt;
  logic            r_err;
  logic [1:0]      r_err_code;
  logic            w_wait;
  logic            w_tmo;
  logic            w_alu_src;
  logic [1:0]      w_aluop;

  // Classify the raw opcode; only sampled in DECODE.
  always_comb begin
    case (i_opcode)
      7'b0110011: w_cls = C_R;
      7'b0010011: w_cls = C_I;
      7'b0000011: w_cls = C_L;
      7'b0100011: w_cls = C_S;
      7'b1100011: w_cls = C_B;
      7'b1101111: w_cls = C_JAL;
      7'b1100111: w_cls = C_JALR;
      7'b0110111: w_cls = C_LUI;
      7'b0010111: w_cls = C_AUIPC;
      7'b1110011: w_cls = C_SYS;
      default:    w_cls = C_ILL;
    endcase
  end

  // A wait cycle is a request cycle without its ack; an ack on the limit cycle wins.
  always_comb begin
    w_wait = ((r_state == S_FETCH) && !i_imem_ack) || ((r_state == S_MEM) && !i_dmem_ack);
    w_tmo  = (TIMEOUT != 0) && w_wait && ((r_wait_cnt + TO_W'(1)) == TO_W'(TIMEOUT));
  end

  // ALU controls from the latched class.
  always_comb begin
    w_alu_src = (r_cls == C_I) || (r_cls == C_L) || (r_cls == C_S) ||
                (r_cls == C_JALR) || (r_cls == C_LUI) || (r_cls == C_AUIPC);
    case (r_cls)
      C_R:     w_aluop = 2'b10;
      C_I:     w_aluop = 2'b11;
      C_B:     w_aluop = 2'b01;
      default: w_aluop = 2'b00;
    endcase
  end

  // Datapath controls; ALU controls stay up through MEM/WB so an unregistered result is stable.
  always_comb begin
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_branch     = 1'b0;
    o_jump       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src    = 1'b0;
    o_reg_write  = 1'b0;
    o_aluop      = 2'b00;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_we    = i_imem_ack;
      end
      S_EXEC: begin
        o_alu_src = w_alu_src;
        o_aluop   = w_aluop;
        o_branch  = (r_cls == C_B);
        o_pc_we   = (r_cls == C_B);
      end
      S_MEM: begin
        o_alu_src   = w_alu_src;
        o_aluop     = w_aluop;
        o_dmem_req  = 1'b1;
        o_mem_read  = (r_cls == C_L);
        o_mem_write = (r_cls == C_S);
        o_pc_we     = (r_cls == C_S) && i_dmem_ack;
      end
      S_WB: begin
        o_alu_src    = w_alu_src;
        o_aluop      = w_aluop;
        o_reg_write  = 1'b1;
        o_pc_we      = 1'b1;
        o_mem_to_reg = (r_cls == C_L);
        o_jump       = (r_cls == C_JAL) || (r_cls == C_JALR);
      end
      default: ;
    endcase
  end

  assign o_halt     = r_halt;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

  // Instruction sequencer with wait counter and sticky halt/error status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cls      <= C_ILL;
      r_wait_cnt <= '0;
      r_halt     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (i_run) r_state <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (!w_wait) begin
            r_wait_cnt <= '0;
            if (r_state == S_FETCH)  r_state <= S_DECODE;
            else if (r_cls == C_L)   r_state <= S_WB;
            else                     r_state <= i_run ? S_FETCH : S_IDLE;
          end else if (w_tmo) begin
            r_wait_cnt <= '0;
            r_state    <= S_HALT;
            r_halt     <= 1'b1;
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
          end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          r_cls <= w_cls;
          if (w_cls == C_SYS) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
          end else if (w_cls == C_ILL) begin
            r_state    <= S_HALT;
            r_halt     <= 1'b1;
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cls == C_B)                        r_state <= i_run ? S_FETCH : S_IDLE;
          else if (r_cls == C_L || r_cls == C_S)   r_state <= S_MEM;
          else                                     r_state <= S_WB;
        end
        S_WB:    r_state <= i_run ? S_FETCH : S_IDLE;
        default: r_state <= S_HALT;
      endcase
    end
  end

`ifdef MCU_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;
  // Count retires (pc_we pulses); no pulse occurs in HALT so it freezes there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_retire_cnt <= '0;
    else if (o_pc_we) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
  end
  assign o_retire_cnt = r_retire_cnt;
`else
  assign o_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized model-checked bench for multicycle_control_unit
module tb_multicycle_control_unit;
  localparam int TMO = 4;
  localparam int TOW = 8;
  localparam int CW  = 4;

  localparam int K_R = 0, K_I = 1, K_L = 2, K_S = 3, K_B = 4, K_JAL = 5, K_JALR = 6,
                 K_LUI = 7, K_AUIPC = 8, K_SYS = 9, K_ILL = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          imem_req, dmem_req, ir_we, pc_we, branch, jump;
  logic          mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic [1:0]    aluop, err_code;
  logic          halt, err;
  logic [CW-1:0] retire_cnt;

  multicycle_control_unit #(.TIMEOUT(TMO), .TO_W(TOW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_opcode(opcode),
    .o_imem_req(imem_req), .i_imem_ack(imem_ack),
    .o_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
    .o_ir_we(ir_we), .o_pc_we(pc_we), .o_branch(branch), .o_jump(jump),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg),
    .o_alu_src(alu_src), .o_reg_write(reg_write), .o_aluop(aluop),
    .o_halt(halt), .o_err(err), .o_err_code(err_code), .o_retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic imem_req; logic dmem_req; logic ir_we; logic pc_we; logic branch; logic jump;
    logic mem_read; logic mem_write; logic mem_to_reg; logic alu_src; logic reg_write;
    logic [1:0] aluop; logic halt; logic err; logic [1:0] err_code; logic [CW-1:0] rc;
  } outv_t;

  typedef struct packed {
    logic run; logic [6:0] op; logic ia; logic da;
  } inv_t;

  outv_t act;
  assign act = {imem_req, dmem_req, ir_we, pc_we, branch, jump, mem_read, mem_write,
                mem_to_reg, alu_src, reg_write, aluop, halt, err, err_code, retire_cnt};

  outv_t eq[$];
  inv_t  iq[$];
  int    checks = 0;
  int    failures = 0;
  int    m_cnt = 0;
  bit    m_halted = 0;
  int    cyc = 0;

  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0010011};

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_L;
      7'b0100011: return K_S;
      7'b1100011: return K_B;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1110011: return K_SYS;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [CW-1:0] rc_exp();
`ifdef MCU_RETIRE_CNT_EN
    return CW'(m_cnt);
`else
    return '0;
`endif
  endfunction

  function automatic outv_t base();
    outv_t e;
    e = '0;
    e.rc = rc_exp();
    return e;
  endfunction

  // ALU controls expected while an instruction of class c occupies EXEC/MEM/WB.
  function automatic outv_t with_alu(input outv_t e0, input int c);
    outv_t e;
    e = e0;
    e.alu_src = (c == K_I || c == K_L || c == K_S || c == K_JALR || c == K_LUI || c == K_AUIPC);
    e.aluop   = (c == K_R) ? 2'b10 : (c == K_I) ? 2'b11 : (c == K_B) ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic inv_t rand_in();
    inv_t i;
    i.run = 1'($urandom);
    i.op  = 7'($urandom);
    i.ia  = 1'($urandom);
    i.da  = 1'($urandom);
    return i;
  endfunction

  task automatic push(input outv_t e, input inv_t i);
    eq.push_back(e);
    iq.push_back(i);
  endtask

  task automatic add_halt(input logic e_err, input logic [1:0] code);
    outv_t e;
    for (int k = 0; k < 20; k++) begin
      e = base();
      e.halt = 1'b1; e.err = e_err; e.err_code = code;
      push(e, rand_in());
    end
    m_halted = 1;
  endtask

  // Retire happened: the count moves on, and the run input decides FETCH or an IDLE gap.
  task automatic retire(input bit rn);
    inv_t i;
    m_cnt++;
    if (!rn) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        i = rand_in(); i.run = 1'b0;
        push(base(), i);
      end
      i = rand_in(); i.run = 1'b1;
      push(base(), i);
    end
  endtask

  // Request phase: dly cycles without ack, then ack, unless the wait limit comes first.
  task automatic add_wait(input bit is_mem, input int c, input int dly,
                          output bit acked, output outv_t e, output inv_t i);
    acked = 0;
    for (int k = 0; k < 1000; k++) begin
      e = base();
      if (is_mem) e = with_alu(e, c);
      e.imem_req = !is_mem; e.dmem_req = is_mem;
      e.mem_read = is_mem && (c == K_L); e.mem_write = is_mem && (c == K_S);
      i = rand_in();
      if (k == dly) begin
        if (is_mem) i.da = 1'b1; else i.ia = 1'b1;
        e.ir_we = !is_mem;
        acked = 1;
        return;
      end
      if (is_mem) i.da = 1'b0; else i.ia = 1'b0;
      push(e, i);
      if (TMO != 0 && k == TMO - 1) return;
    end
  endtask

  task automatic add_instr(input logic [6:0] op, input int fd, input int md, input bit rn);
    outv_t e;
    inv_t  i;
    bit    ok;
    int    c;
    if (m_halted) return;
    c = cls_of(op);
    add_wait(0, c, fd, ok, e, i);
    if (!ok) begin add_halt(1'b1, 2'b10); return; end
    push(e, i);
    i = rand_in(); i.op = op;
    push(base(), i);
    if (c == K_SYS) begin add_halt(1'b0, 2'b00); return; end
    if (c == K_ILL) begin add_halt(1'b1, 2'b01); return; end
    e = with_alu(base(), c);
    i = rand_in(); i.op = op;
    if (c == K_B) begin
      e.branch = 1'b1; e.pc_we = 1'b1; i.run = rn;
      push(e, i); retire(rn); return;
    end
    push(e, i);
    if (c == K_L || c == K_S) begin
      add_wait(1, c, md, ok, e, i);
      if (!ok) begin add_halt(1'b1, 2'b10); return; end
      if (c == K_S) begin
        e.pc_we = 1'b1; i.run = rn;
        push(e, i); retire(rn); return;
      end
      push(e, i);
    end
    e = with_alu(base(), c);
    e.reg_write = 1'b1; e.pc_we = 1'b1;
    e.mem_to_reg = (c == K_L);
    e.jump = (c == K_JAL || c == K_JALR);
    i = rand_in(); i.run = rn;
    push(e, i); retire(rn);
  endtask

  task automatic check_lit(input string name, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, x);
    end
  endtask

  task automatic check_out(input int k);
    checks++;
    if (act !== eq[k]) begin
      failures++;
      $display("FAIL cycle %0d (step %0d) outputs actual=%h expected=%h", cyc, k, act, eq[k]);
    end
  endtask

  task automatic run_q(input int n);
    int lim;
    lim = (n < 0 || n > eq.size()) ? eq.size() : n;
    for (int k = 0; k < lim; k++) begin
      run = iq[k].run; opcode = iq[k].op; imem_ack = iq[k].ia; dmem_ack = iq[k].da;
      @(negedge clk);
      check_out(k);
      cyc++;
      @(posedge clk);
      #1;
    end
    eq.delete();
    iq.delete();
  endtask

  task automatic start_round();
    inv_t i;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #2;
    check_lit("reset_outputs_zero", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 0; m_halted = 0;
    eq.delete(); iq.delete();
    i = rand_in(); i.run = 1'b1;
    push(base(), i);
  endtask

  function automatic int count_field(input int s0, input int which);
    int n = 0;
    for (int k = s0; k < eq.size(); k++) begin
      case (which)
        0: n += int'(eq[k].mem_read);
        1: n += int'(eq[k].reg_write);
        2: n += int'(eq[k].imem_req);
        default: n += int'(eq[k].halt);
      endcase
    end
    return n;
  endfunction

  initial begin
    int s0;
    logic [6:0] op;
    int fd, md;

    // Round 1: one of each main class, ending on an illegal opcode.
    start_round();
    add_instr(7'b0110011, 0, 0, 1);
    check_lit("model_r_len", 32'(eq.size()), 32'd5);
    check_lit("model_r_irwe_c1", 32'(eq[1].ir_we), 32'd1);
    check_lit("model_r_wb_c4", {29'd0, eq[4].reg_write, eq[4].aluop}, {29'd0, 1'b1, 2'b10});
    s0 = eq.size();
    add_instr(7'b0000011, 0, 3, 1);
    check_lit("model_load_memread_cycles", 32'(count_field(s0, 0)), 32'd4);
    check_lit("model_load_memtoreg", 32'(eq[eq.size()-1].mem_to_reg), 32'd1);
    s0 = eq.size();
    add_instr(7'b0100011, 0, 1, 1);
    check_lit("model_store_no_regwrite", 32'(count_field(s0, 1)), 32'd0);
    s0 = eq.size();
    add_instr(7'b1100011, 0, 0, 1);
    check_lit("model_branch_len", 32'(eq.size() - s0), 32'd3);
    add_instr(7'b1101111, 1, 0, 0);
    add_instr(7'b0110111, 0, 0, 1);
    add_instr(7'b1111111, 0, 0, 1);
    check_lit("model_ill_code", {30'd0, eq[eq.size()-1].err_code}, 32'd1);
    run_q(-1);

    // Round 2: SYSTEM halts without error.
    start_round();
    add_instr(7'b0010011, 2, 0, 1);
    add_instr(7'b1110011, 0, 0, 1);
    check_lit("model_sys_err", {31'd0, eq[eq.size()-1].err}, 32'd0);
    run_q(-1);

    // Round 3: fetch never acked -> timeout.
    start_round();
    s0 = eq.size();
    add_instr(7'b0110011, 1000, 0, 1);
    check_lit("model_tmo_req_cycles", 32'(count_field(s0, 2)), 32'(TMO));
    run_q(-1);
    check_lit("dut_tmo_err_code", {30'd0, err_code}, 32'd2);

    // Round 4: acks on the last allowed cycle win over the timeout.
    start_round();
    add_instr(7'b0110011, TMO - 1, 0, 1);
    add_instr(7'b0000011, TMO - 1, TMO - 1, 1);
    add_instr(7'b0100011, 0, TMO - 1, 1);
    check_lit("model_edge_no_halt", 32'(count_field(0, 3)), 32'd0);
    run_q(-1);
    check_lit("dut_edge_no_halt", {31'd0, halt}, 32'd0);

    // Round 5: 17 R-type retires wrap a 4-bit counter to 1, then reset mid-MEM.
    start_round();
    for (int n = 0; n < 17; n++) add_instr(7'b0110011, 0, 0, 1);
    run_q(-1);
`ifdef MCU_RETIRE_CNT_EN
    check_lit("dut_retire_wrap", 32'(retire_cnt), 32'd1);
`else
    check_lit("dut_retire_tied", 32'(retire_cnt), 32'd0);
`endif
    add_instr(7'b0000011, 0, 3, 1);
    run_q(5);
    check_lit("dut_in_mem_before_reset", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_lit("dut_reset_mid_mem", 32'(act), 32'd0);
    #1;

    // Random rounds.
    for (int r = 0; r < 6; r++) begin
      start_round();
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 99) < 3) op = 7'($urandom);
        else if ($urandom_range(0, 99) < 2) op = 7'b1110011;
        else op = legal_ops[$urandom_range(0, 9)];
        fd = ($urandom_range(0, 99) < 3) ? TMO + 2 : int'($urandom_range(0, TMO - 1));
        md = ($urandom_range(0, 99) < 3) ? TMO + 2 : int'($urandom_range(0, TMO - 1));
        add_instr(op, fd, md, ($urandom_range(0, 3) != 0));
      end
      run_q(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
